// File: rtl/riscv_pkg.sv
// Shared widths, writeback FSM state type and load funct3 encodings.
package riscv_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned FUNCT3_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } wb_state_t;

    localparam logic [2:0] LB_F3  = 3'd0;
    localparam logic [2:0] LH_F3  = 3'd1;
    localparam logic [2:0] LW_F3  = 3'd2;
    localparam logic [2:0] LBU_F3 = 3'd4;
    localparam logic [2:0] LHU_F3 = 3'd5;

endpackage

// File: rtl/load_align.sv
// Load data extraction and extension, plus the illegal/misaligned check.
// Purely combinational; the error flag depends only on offset and funct3.
module load_align
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned FUNCT3_W = 3
) (
    input  logic [XLEN-1:0]     word_i,
    input  logic [1:0]          offset_i,
    input  logic [FUNCT3_W-1:0] funct3_i,
    output logic [XLEN-1:0]     data_o,
    output logic                err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword, then extend according to load type.
    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        half_sel = word_i[{offset_i[1], 4'b0000} +: 16];
        data_o   = '0;
        err_o    = 1'b0;
        case (funct3_i)
            LB_F3: begin
                data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            end
            LH_F3: begin
                data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
                err_o  = offset_i[0];
            end
            LW_F3: begin
                data_o = word_i;
                err_o  = |offset_i;
            end
            LBU_F3: begin
                data_o = {{(XLEN-8){1'b0}}, byte_sel};
            end
            LHU_F3: begin
                data_o = {{(XLEN-16){1'b0}}, half_sel};
                err_o  = offset_i[0];
            end
            default: begin
                err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: writes ALU results directly and performs loads through a
// request/response data-memory port before writing the extended data back.
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned RF_ADDR_WIDTH = 5,
    parameter int unsigned FUNCT3_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [RF_ADDR_WIDTH-1:0] ex_rd,
    input  logic [XLEN-1:0]          ex_result,
    input  logic                     ex_is_load,
    input  logic [FUNCT3_W-1:0]      ex_funct3,
    output logic                     dmem_req_valid,
    input  logic                     dmem_req_ready,
    output logic [XLEN-1:0]          dmem_addr,
    input  logic                     dmem_rsp_valid,
    input  logic [XLEN-1:0]          dmem_rsp_data,
    output logic                     rf_we,
    output logic [RF_ADDR_WIDTH-1:0] rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     wb_pending,
    output logic [RF_ADDR_WIDTH-1:0] wb_pending_rd,
    output logic                     load_err
);

    wb_state_t                  state_q, state_d;
    logic [RF_ADDR_WIDTH-1:0]   rd_q, rd_d;
    logic [FUNCT3_W-1:0]        f3_q, f3_d;
    logic [1:0]                 off_q, off_d;
    logic [XLEN-1:0]            addr_q, addr_d;
    logic                       rf_we_q, rf_we_d;
    logic [RF_ADDR_WIDTH-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]            rf_wdata_q, rf_wdata_d;
    logic                       load_err_q, load_err_d;

    logic                       accept;
    logic [1:0]                 off_sel;
    logic [FUNCT3_W-1:0]        f3_sel;
    logic [XLEN-1:0]            ext_data;
    logic                       align_err;

    // One aligner serves both uses: in IDLE it checks the incoming load, otherwise
    // it extends the response using the captured offset/funct3.
    always_comb begin
        off_sel = (state_q == IDLE) ? ex_result[1:0] : off_q;
        f3_sel  = (state_q == IDLE) ? ex_funct3 : f3_q;
    end

    load_align #(
        .XLEN     (XLEN),
        .FUNCT3_W (FUNCT3_W)
    ) u_load_align (
        .word_i   (dmem_rsp_data),
        .offset_i (off_sel),
        .funct3_i (f3_sel),
        .data_o   (ext_data),
        .err_o    (align_err)
    );

    assign accept = ex_valid && ex_ready;

    // Next-state and registered-output logic for the IDLE/REQ/WAIT sequence.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        off_d      = off_q;
        addr_d     = addr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        load_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!ex_is_load) begin
                        // rd=0 writes are dropped entirely
                        rf_we_d    = (ex_rd != '0);
                        rf_waddr_d = ex_rd;
                        rf_wdata_d = ex_result;
                    end else if (align_err) begin
                        load_err_d = 1'b1;
                    end else begin
                        rd_d    = ex_rd;
                        f3_d    = ex_funct3;
                        off_d   = ex_result[1:0];
                        addr_d  = {ex_result[XLEN-1:2], 2'b00};
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dmem_rsp_valid) begin
                    rf_we_d    = (rd_q != '0);
                    rf_waddr_d = rd_q;
                    rf_wdata_d = ext_data;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            addr_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            addr_q     <= addr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            load_err_q <= load_err_d;
        end
    end

    // Status and handshake outputs derived from the current state.
    always_comb begin
        ex_ready       = !rst && (state_q == IDLE);
        dmem_req_valid = (state_q == REQ);
        dmem_addr      = (state_q == REQ) ? addr_q : '0;
        wb_pending     = (state_q == REQ) || (state_q == WAIT);
        wb_pending_rd  = wb_pending ? rd_q : '0;
        rf_we          = rf_we_q;
        rf_waddr       = rf_waddr_q;
        rf_wdata       = rf_wdata_q;
        load_err       = load_err_q;
    end

endmodule
